// File: rtl/objdma_sequencer.sv
// Per-frame sprite-attribute DMA: copies object RAM into the sprite engine's
// double-buffered object buffer, one byte every two pixel ticks, and arbitrates CPU access.
module objdma_sequencer #(
  parameter int ADDR_W  = 11,
  parameter int DMA_LEN = 2048
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_RST,
  input  logic              i_EMU_CLK6MPCEN_n,
  input  logic              i_DMA_n,
  input  logic              i_VBLANK_n,
  input  logic              i_CPU_REQ,
  output logic              o_CPU_WAIT_n,
  output logic              o_RAM_SEL,
  output logic [ADDR_W-1:0] o_RAM_ADDR,
  output logic              o_RAM_RD,
  input  logic [7:0]        i_RAM_DATA,
  output logic [ADDR_W-1:0] o_BUF_ADDR,
  output logic [7:0]        o_BUF_DATA,
  output logic              o_BUF_WR,
  output logic              o_BUF_BANK,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_ABORT
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  // cnt carries one spare bit so a full 2^ADDR_W copy never wraps
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DMA_LEN - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  state_t            state, state_nx;
  logic [ADDR_W:0]   cnt, cnt_nx;
  logic              dma_q;
  logic              tick, start;
  logic [ADDR_W-1:0] ram_addr_nx, buf_addr_nx;
  logic [7:0]        buf_data_nx;
  logic              ram_sel_nx, ram_rd_nx, buf_wr_nx, bank_nx, busy_nx, done_nx, abort_nx;

  assign tick         = !i_EMU_CLK6MPCEN_n;
  assign start        = dma_q && !i_DMA_n;
  assign o_CPU_WAIT_n = !(i_CPU_REQ && o_BUSY);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    ram_addr_nx = o_RAM_ADDR;
    buf_addr_nx = o_BUF_ADDR;
    buf_data_nx = o_BUF_DATA;
    ram_sel_nx  = o_RAM_SEL;
    ram_rd_nx   = 1'b0;
    buf_wr_nx   = 1'b0;
    bank_nx     = o_BUF_BANK;
    busy_nx     = o_BUSY;
    done_nx     = 1'b0;
    abort_nx    = o_ABORT;
    case (state)
      IDLE: if (start) begin
        // a window opening during active display is bogus; flag it and stay idle
        if (i_VBLANK_n) abort_nx = 1'b1;
        else begin
          state_nx   = READ;
          cnt_nx     = '0;
          busy_nx    = 1'b1;
          ram_sel_nx = 1'b1;
          abort_nx   = 1'b0;
        end
      end
      READ: begin
        if (i_DMA_n) begin
          state_nx   = IDLE;
          abort_nx   = 1'b1;
          busy_nx    = 1'b0;
          ram_sel_nx = 1'b0;
        end else begin
          ram_addr_nx = cnt[ADDR_W-1:0];
          ram_rd_nx   = 1'b1;
          state_nx    = WRITE;
        end
      end
      WRITE: begin
        buf_data_nx = i_RAM_DATA;
        buf_addr_nx = cnt[ADDR_W-1:0];
        buf_wr_nx   = 1'b1;
        if (i_DMA_n) begin
          // the in-flight byte still lands; bank is left alone so the engine keeps the old frame
          state_nx   = IDLE;
          abort_nx   = 1'b1;
          busy_nx    = 1'b0;
          ram_sel_nx = 1'b0;
        end else if (cnt == LAST) begin
          state_nx = DONE;
        end else begin
          cnt_nx   = cnt + ONE;
          state_nx = READ;
        end
      end
      DONE: begin
        done_nx    = 1'b1;
        bank_nx    = !o_BUF_BANK;
        busy_nx    = 1'b0;
        ram_sel_nx = 1'b0;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_RST) begin
      state      <= IDLE;
      cnt        <= '0;
      dma_q      <= 1'b0;
      o_RAM_ADDR <= '0;
      o_BUF_ADDR <= '0;
      o_BUF_DATA <= '0;
      o_RAM_SEL  <= 1'b0;
      o_RAM_RD   <= 1'b0;
      o_BUF_WR   <= 1'b0;
      o_BUF_BANK <= 1'b0;
      o_BUSY     <= 1'b0;
      o_DONE     <= 1'b0;
      o_ABORT    <= 1'b0;
    end else if (tick) begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      dma_q      <= i_DMA_n;
      o_RAM_ADDR <= ram_addr_nx;
      o_BUF_ADDR <= buf_addr_nx;
      o_BUF_DATA <= buf_data_nx;
      o_RAM_SEL  <= ram_sel_nx;
      o_RAM_RD   <= ram_rd_nx;
      o_BUF_WR   <= buf_wr_nx;
      o_BUF_BANK <= bank_nx;
      o_BUSY     <= busy_nx;
      o_DONE     <= done_nx;
      o_ABORT    <= abort_nx;
    end
  end

endmodule

// File: tb/tb_objdma_sequencer.sv
// Directed bench for objdma_sequencer: full copies, bank flip, abort, CPU stall,
// sparse pixel enable and mid-copy reset, with an RAM model of RAM[a] = a[7:0] ^ ram_xor.
module tb_objdma_sequencer;
  localparam int ADDR_W  = 11;
  localparam int DMA_LEN = 2048;

  logic clk = 1'b0, rst = 1'b1, cen_n = 1'b0, dma_n = 1'b1, vblank_n = 1'b0, cpu_req = 1'b0;
  logic [7:0] ram_data;
  logic [7:0] ram_xor = 8'h00;
  logic wait_n, ram_sel, ram_rd, buf_wr, bank, busy, done, abort;
  logic [ADDR_W-1:0] ram_addr, buf_addr;
  logic [7:0] buf_data;

  objdma_sequencer #(.ADDR_W(ADDR_W), .DMA_LEN(DMA_LEN)) dut (
    .i_EMU_MCLK(clk), .i_RST(rst), .i_EMU_CLK6MPCEN_n(cen_n), .i_DMA_n(dma_n),
    .i_VBLANK_n(vblank_n), .i_CPU_REQ(cpu_req), .o_CPU_WAIT_n(wait_n),
    .o_RAM_SEL(ram_sel), .o_RAM_ADDR(ram_addr), .o_RAM_RD(ram_rd), .i_RAM_DATA(ram_data),
    .o_BUF_ADDR(buf_addr), .o_BUF_DATA(buf_data), .o_BUF_WR(buf_wr), .o_BUF_BANK(bank),
    .o_BUSY(busy), .o_DONE(done), .o_ABORT(abort)
  );

  assign ram_data = ram_addr[7:0] ^ ram_xor;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // pixel enable: always low, or low on one MCLK edge in four; hold_cen forces non-tick edges
  int cen_div = 1;
  logic hold_cen = 1'b0;
  logic [1:0] ph = 2'd0;
  always @(negedge clk) begin
    cen_n <= hold_cen ? 1'b1 : ((cen_div == 4) ? (ph != 2'd3) : 1'b0);
    ph    <= ph + 2'd1;
  end

  // write monitor: counts buffer writes at ticks and checks address/data/spacing in order
  int mcnt = 0, idx = 0, wr_cnt = 0, wr_bad = 0, gap_bad = 0, done_cnt = 0, last_wr_mc = 0, exp_gap = 2;
  int last_wr_addr = -1;
  logic tick_seen = 1'b0, busy_prev = 1'b0;
  always @(posedge clk) begin
    mcnt      <= mcnt + 1;
    tick_seen <= !cen_n;
  end
  always @(negedge clk) if (tick_seen) begin
    if (busy && !busy_prev) idx = 0;
    busy_prev = busy;
    if (buf_wr) begin
      if (buf_addr !== ADDR_W'(idx) || buf_data !== (8'(idx) ^ ram_xor)) wr_bad++;
      if (idx > 0 && (mcnt - last_wr_mc) != exp_gap) gap_bad++;
      last_wr_mc   = mcnt;
      last_wr_addr = int'(buf_addr);
      idx++;
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    do @(posedge clk); while (cen_n);
    @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // returns after the start tick (tick 0)
  task automatic start_frame();
    dma_n = 1'b1;
    tick_n(2);
    dma_n = 1'b0;
    tick();
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dma_n = 1'b1;
    tick_n(3);
    rst = 1'b0;
    tick();
    n_chk++; if ({ram_sel, ram_rd, buf_wr, bank, busy, done, abort, wait_n} !== 8'b0000_0001) begin n_fail++; $display("FAIL reset_flags: got %b want 00000001", {ram_sel, ram_rd, buf_wr, bank, busy, done, abort, wait_n}); end
    n_chk++; if ({ram_addr, buf_addr, buf_data} !== '0) begin n_fail++; $display("FAIL reset_buses: got %0h want 0", {ram_addr, buf_addr, buf_data}); end
  endtask

  task automatic test_frame();
    int n, w0, b0, g0, d0;
    ram_xor = 8'h00; exp_gap = 2;
    w0 = wr_cnt; b0 = wr_bad; g0 = gap_bad; d0 = done_cnt;
    start_frame();
    n_chk++; if ({busy, ram_sel} !== 2'b11) begin n_fail++; $display("FAIL frame_start: got busy,sel=%b want 11", {busy, ram_sel}); end
    run_to_done(n);
    n_chk++; if (n !== 4097) begin n_fail++; $display("FAIL frame_done_tick: got %0d want 4097", n); end
    tick();
    n_chk++; if (wr_cnt - w0 !== 2048) begin n_fail++; $display("FAIL frame_wr_count: got %0d want 2048", wr_cnt - w0); end
    n_chk++; if (wr_bad - b0 !== 0) begin n_fail++; $display("FAIL frame_wr_data: got %0d bad writes want 0", wr_bad - b0); end
    n_chk++; if (gap_bad - g0 !== 0) begin n_fail++; $display("FAIL frame_wr_gap: got %0d bad gaps want 0", gap_bad - g0); end
    n_chk++; if (last_wr_addr !== 2047) begin n_fail++; $display("FAIL frame_last_addr: got %0d want 2047", last_wr_addr); end
    n_chk++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL frame_done_pulses: got %0d want 1", done_cnt - d0); end
    n_chk++; if ({bank, abort, busy, ram_sel} !== 4'b1000) begin n_fail++; $display("FAIL frame_end_flags: got bank,abort,busy,sel=%b want 1000", {bank, abort, busy, ram_sel}); end
  endtask

  task automatic test_back_to_back();
    int n, w0, b0;
    ram_xor = 8'h5A;
    w0 = wr_cnt; b0 = wr_bad;
    start_frame();
    tick_n(100);
    // glitch on DMA_n seen only on non-tick edges
    hold_cen = 1'b1;
    @(negedge clk); dma_n = 1'b1;
    @(negedge clk); dma_n = 1'b0; hold_cen = 1'b0;
    run_to_done(n);
    tick();
    n_chk++; if (n === 5000) begin n_fail++; $display("FAIL b2b_timeout: got no done want done"); end
    n_chk++; if (wr_cnt - w0 !== 2048) begin n_fail++; $display("FAIL b2b_wr_count: got %0d want 2048", wr_cnt - w0); end
    n_chk++; if (wr_bad - b0 !== 0) begin n_fail++; $display("FAIL b2b_wr_data: got %0d bad writes want 0", wr_bad - b0); end
    n_chk++; if ({bank, abort} !== 2'b00) begin n_fail++; $display("FAIL b2b_bank: got bank,abort=%b want 00", {bank, abort}); end
  endtask

  task automatic test_abort();
    int n, w0, d0;
    logic b;
    ram_xor = 8'h00;
    b = bank; w0 = wr_cnt; d0 = done_cnt;
    start_frame();
    tick_n(1001);
    dma_n = 1'b1;
    tick();
    n_chk++; if ({buf_wr, buf_addr} !== {1'b1, 11'd500}) begin n_fail++; $display("FAIL abort_last_write: got wr=%b addr=%0d want wr=1 addr=500", buf_wr, buf_addr); end
    n_chk++; if ({abort, busy, ram_sel} !== 3'b100) begin n_fail++; $display("FAIL abort_flags: got abort,busy,sel=%b want 100", {abort, busy, ram_sel}); end
    tick_n(10);
    n_chk++; if (wr_cnt - w0 !== 501) begin n_fail++; $display("FAIL abort_wr_count: got %0d want 501", wr_cnt - w0); end
    n_chk++; if (done_cnt - d0 !== 0 || bank !== b || abort !== 1'b1) begin n_fail++; $display("FAIL abort_hold: got done=%0d bank=%b abort=%b want 0 %b 1", done_cnt - d0, bank, abort, b); end
    start_frame();
    n_chk++; if (abort !== 1'b0) begin n_fail++; $display("FAIL abort_clear: got %b want 0", abort); end
    run_to_done(n);
    tick();
    n_chk++; if (bank !== !b) begin n_fail++; $display("FAIL abort_next_bank: got %b want %b", bank, !b); end
  endtask

  task automatic test_vblank_guard();
    int w0;
    w0 = wr_cnt;
    vblank_n = 1'b1;
    start_frame();
    tick_n(5);
    n_chk++; if ({busy, abort} !== 2'b01 || wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL vblank_guard: got busy,abort=%b writes=%0d want 01 0", {busy, abort}, wr_cnt - w0); end
    vblank_n = 1'b0;
  endtask

  task automatic test_cpu_wait();
    int n, bad;
    logic wait_at_done;
    bad = 0;
    cpu_req = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); if (wait_n !== 1'b1) bad++; end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL cpu_idle_wait: got %0d stalled ticks want 0", bad); end
    cpu_req = 1'b0;
    start_frame();
    tick_n(10);
    cpu_req = 1'b1;
    n = 10; bad = 0;
    while (done !== 1'b1 && n < 5000) begin
      tick(); n++;
      if (done !== 1'b1 && wait_n !== 1'b0) bad++;
    end
    wait_at_done = wait_n;
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL cpu_busy_wait: got %0d unstalled ticks want 0", bad); end
    n_chk++; if ({n, wait_at_done} !== {32'd4097, 1'b1}) begin n_fail++; $display("FAIL cpu_release: got tick=%0d wait_n=%b want 4097 1", n, wait_at_done); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_cen_sparse();
    int n, w0, b0, g0;
    cen_div = 4; exp_gap = 8; ram_xor = 8'hC3;
    tick_n(3);
    w0 = wr_cnt; b0 = wr_bad; g0 = gap_bad;
    start_frame();
    run_to_done(n);
    tick();
    n_chk++; if (n !== 4097) begin n_fail++; $display("FAIL cen_done_tick: got %0d want 4097", n); end
    n_chk++; if (wr_cnt - w0 !== 2048 || wr_bad - b0 !== 0) begin n_fail++; $display("FAIL cen_writes: got count=%0d bad=%0d want 2048 0", wr_cnt - w0, wr_bad - b0); end
    n_chk++; if (gap_bad - g0 !== 0) begin n_fail++; $display("FAIL cen_spacing: got %0d bad gaps want 0", gap_bad - g0); end
    cen_div = 1; exp_gap = 2; ram_xor = 8'h00;
    tick_n(3);
  endtask

  task automatic test_reset_mid_copy();
    int n, w0, b0;
    w0 = wr_cnt;
    start_frame();
    tick_n(1401);
    rst = 1'b1;
    tick();
    n_chk++; if ({ram_sel, ram_rd, buf_wr, bank, busy, done, abort, wait_n} !== 8'b0000_0001) begin n_fail++; $display("FAIL midreset_flags: got %b want 00000001", {ram_sel, ram_rd, buf_wr, bank, busy, done, abort, wait_n}); end
    n_chk++; if ({ram_addr, buf_addr, buf_data} !== '0) begin n_fail++; $display("FAIL midreset_buses: got %0h want 0", {ram_addr, buf_addr, buf_data}); end
    rst = 1'b0;
    tick_n(20);
    n_chk++; if (wr_cnt - w0 !== 700) begin n_fail++; $display("FAIL midreset_wr_count: got %0d want 700", wr_cnt - w0); end
    w0 = wr_cnt; b0 = wr_bad;
    start_frame();
    run_to_done(n);
    tick();
    n_chk++; if (wr_cnt - w0 !== 2048 || wr_bad - b0 !== 0) begin n_fail++; $display("FAIL midreset_restart: got count=%0d bad=%0d want 2048 0", wr_cnt - w0, wr_bad - b0); end
    n_chk++; if (bank !== 1'b1) begin n_fail++; $display("FAIL midreset_bank: got %b want 1", bank); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_abort();
    test_vblank_guard();
    test_cpu_wait();
    test_cen_sparse();
    test_reset_mid_copy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
